run_monitor: RTL and testbench

Parametrised run/halt monitor for the pipeline CPU. It counts cycles and NUM_EVT per-event counters (retire, stall, flush, …). It latches the program return value on halt and applies an optional drain window before declaring done. It detects runaway programs via a cycle limit. Synthesizable core, optional simulation reporting; instantiated beside the CPU top in bench and FPGA builds.

---
 rtl/run_monitor_pkg.sv | 18 +
 rtl/sat_counter.sv | 23 ++
 rtl/run_monitor.sv | 140 ++++++++++++++
 tb/tb_run_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared state encoding and width helpers for run_monitor.
package run_monitor_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // Width of a select/counter field that must be at least one bit wide.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority over counting; saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: run/halt monitor for the pipeline CPU. Counts cycles and
// per-channel events, latches the return value on halt, optionally drains
// for DRAIN_CYCLES before declaring done, and flags runaway programs.
// Optional macro RUN_MONITOR_SIM_REPORT_EN enables simulation-only reporting
// and ends the simulation when the run completes.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 50000000,
  parameter int NUM_EVT      = 4,
  parameter int EVT_W        = 32,
  parameter int RET_W        = 16,
  parameter int DRAIN_CYCLES = 0,
  localparam int SEL_W       = min1_clog2(NUM_EVT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt_i,
  input  logic [RET_W-1:0]   ret_val_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               restart_i,
  input  logic [SEL_W-1:0]   evt_sel_i,
  output logic [STATE_W-1:0] state_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   cycle_count_o,
  output logic [RET_W-1:0]   ret_val_o,
  output logic [EVT_W-1:0]   evt_count_o
);

  localparam int DRAIN_W    = min1_clog2(DRAIN_CYCLES);
  localparam int DRAIN_INIT = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

  state_t             state;
  logic [CNT_W-1:0]   cycle_count;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [RET_W-1:0]   ret_val;
  logic               counting;
  logic               clr_all;
  logic [EVT_W-1:0]   evt_cnt [NUM_EVT];

  assign counting = (state == ST_RUN) || (state == ST_DRAIN);
  assign clr_all  = restart_i && ((state == ST_HALTED) || (state == ST_TIMEOUT));

  // Run FSM with cycle counter, drain countdown and return-value latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      cycle_count <= '0;
      drain_cnt   <= '0;
      ret_val     <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_i) begin
            // Halt beats the cycle limit when both happen together.
            ret_val     <= ret_val_i;
            cycle_count <= cycle_count + 1'b1;
            if (DRAIN_CYCLES == 0) begin
              state <= ST_HALTED;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_W'(DRAIN_INIT);
            end
          end else if (cycle_count == MAX_CNT) begin
            state <= ST_TIMEOUT;
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        ST_DRAIN: begin
          cycle_count <= cycle_count + 1'b1;
          if (drain_cnt == '0) begin
            state <= ST_HALTED;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
          if (restart_i) begin
            state       <= ST_RUN;
            cycle_count <= '0;
            drain_cnt   <= '0;
            ret_val     <= '0;
          end
        end
      endcase
    end
  end

  // One saturating counter per event channel, live only in RUN/DRAIN.
  for (genvar g = 0; g < NUM_EVT; g++) begin : g_evt
    sat_counter #(.W(EVT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_all),
      .en    (evt_i[g] && counting),
      .count (evt_cnt[g])
    );
  end

  // Readout mux; selects beyond the last channel read as zero.
  always_comb begin
    evt_count_o = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (evt_sel_i == SEL_W'(i)) evt_count_o = evt_cnt[i];
    end
  end

  assign state_o       = state;
  assign done_o        = (state == ST_HALTED) || (state == ST_TIMEOUT);
  assign timeout_o     = (state == ST_TIMEOUT);
  assign cycle_count_o = cycle_count;
  assign ret_val_o     = ret_val;

`ifdef RUN_MONITOR_SIM_REPORT_EN
  state_t prev_state;

  // Report once on entry to a done state, then end the simulation.
  always @(posedge clk) begin
    prev_state <= state;
    if (state == ST_HALTED && prev_state != ST_HALTED) begin
      $display("Finished with << %0d >>", ret_val);
      for (int i = 0; i < NUM_EVT; i++) begin
        $display("event[%0d] = %0d", i, evt_cnt[i]);
      end
      $display("cycles = %0d", cycle_count);
      $finish;
    end else if (state == ST_TIMEOUT && prev_state != ST_TIMEOUT) begin
      $display("ran for %0d cycles", MAX_CYCLES);
      $finish;
    end
  end
`else
  // Resident build: no reporting; the monitor stays up and restart_i works.
`endif

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed table-driven checks of run_monitor, with two
// instances (no drain / 3-cycle drain) sharing one set of stimulus.
module tb_run_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [15:0] ret_in;
  logic [2:0]  evt;
  logic        restart;
  logic [1:0]  sel;

  logic [1:0]  a_state, b_state;
  logic        a_done, b_done, a_to, b_to;
  logic [15:0] a_cc, b_cc, a_ret, b_ret;
  logic [3:0]  a_evt, b_evt;

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  run_monitor #(.CNT_W(16), .MAX_CYCLES(100), .NUM_EVT(3), .EVT_W(4),
                .RET_W(16), .DRAIN_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .halt_i(halt), .ret_val_i(ret_in), .evt_i(evt),
    .restart_i(restart), .evt_sel_i(sel), .state_o(a_state), .done_o(a_done),
    .timeout_o(a_to), .cycle_count_o(a_cc), .ret_val_o(a_ret),
    .evt_count_o(a_evt));

  run_monitor #(.CNT_W(16), .MAX_CYCLES(100), .NUM_EVT(3), .EVT_W(4),
                .RET_W(16), .DRAIN_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .halt_i(halt), .ret_val_i(ret_in), .evt_i(evt),
    .restart_i(restart), .evt_sel_i(sel), .state_o(b_state), .done_o(b_done),
    .timeout_o(b_to), .cycle_count_o(b_cc), .ret_val_o(b_ret),
    .evt_count_o(b_evt));

  typedef struct packed {
    logic        halt;
    logic [15:0] ret;
    logic [2:0]  evt;
    logic        restart;
    logic [1:0]  sel;
    logic [1:0]  e_st;
    logic [15:0] e_cc;
    logic [15:0] e_ret;
    logic [3:0]  e_evt;
  } vec_t;

  vec_t vec [16];

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    halt = 1'b0; ret_in = '0; evt = '0; restart = 1'b0; sel = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Basic halt on u_a (no drain), then frozen readout and restart.
    vec[0]  = '{1'b0, 16'h0000, 3'b001, 1'b0, 2'd0, 2'd0, 16'd1,  16'd0,  4'd1};
    vec[1]  = '{1'b0, 16'h0000, 3'b001, 1'b0, 2'd0, 2'd0, 16'd2,  16'd0,  4'd2};
    vec[2]  = '{1'b0, 16'h0000, 3'b001, 1'b0, 2'd0, 2'd0, 16'd3,  16'd0,  4'd3};
    vec[3]  = '{1'b0, 16'h0000, 3'b001, 1'b0, 2'd0, 2'd0, 16'd4,  16'd0,  4'd4};
    vec[4]  = '{1'b0, 16'h0000, 3'b001, 1'b0, 2'd0, 2'd0, 16'd5,  16'd0,  4'd5};
    vec[5]  = '{1'b0, 16'h0000, 3'b000, 1'b0, 2'd0, 2'd0, 16'd6,  16'd0,  4'd5};
    vec[6]  = '{1'b0, 16'h0000, 3'b000, 1'b1, 2'd3, 2'd0, 16'd7,  16'd0,  4'd0};
    vec[7]  = '{1'b0, 16'h0000, 3'b010, 1'b0, 2'd1, 2'd0, 16'd8,  16'd0,  4'd1};
    vec[8]  = '{1'b0, 16'h0000, 3'b000, 1'b0, 2'd0, 2'd0, 16'd9,  16'd0,  4'd5};
    vec[9]  = '{1'b0, 16'h0000, 3'b000, 1'b0, 2'd0, 2'd0, 16'd10, 16'd0,  4'd5};
    vec[10] = '{1'b1, 16'h002A, 3'b000, 1'b0, 2'd0, 2'd2, 16'd11, 16'd42, 4'd5};
    vec[11] = '{1'b1, 16'h0007, 3'b111, 1'b0, 2'd0, 2'd2, 16'd11, 16'd42, 4'd5};
    vec[12] = '{1'b0, 16'h0000, 3'b111, 1'b0, 2'd1, 2'd2, 16'd11, 16'd42, 4'd1};
    vec[13] = '{1'b0, 16'h0000, 3'b000, 1'b0, 2'd3, 2'd2, 16'd11, 16'd42, 4'd0};
    vec[14] = '{1'b0, 16'h0000, 3'b000, 1'b1, 2'd0, 2'd0, 16'd0,  16'd0,  4'd0};
    vec[15] = '{1'b0, 16'h0000, 3'b001, 1'b0, 2'd0, 2'd0, 16'd1,  16'd0,  4'd1};

    idle_inputs();
    rst = 1'b1;
    #2;
    chk("reset_state", a_state, 0);
    chk("reset_done", a_done, 0);
    chk("reset_timeout", a_to, 0);
    chk("reset_cc", a_cc, 0);
    chk("reset_ret", a_ret, 0);
    chk("reset_evt", a_evt, 0);
    step();
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      halt = vec[k].halt; ret_in = vec[k].ret; evt = vec[k].evt;
      restart = vec[k].restart; sel = vec[k].sel;
      step();
      chk($sformatf("vec%0d_state", k), a_state, vec[k].e_st);
      chk($sformatf("vec%0d_done", k), a_done, vec[k].e_st[1]);
      chk($sformatf("vec%0d_timeout", k), a_to, vec[k].e_st == 2'd3);
      chk($sformatf("vec%0d_cc", k), a_cc, vec[k].e_cc);
      chk($sformatf("vec%0d_ret", k), a_ret, vec[k].e_ret);
      chk($sformatf("vec%0d_evt", k), a_evt, vec[k].e_evt);
    end

    // Timeout: never halt; count stops at the limit.
    do_reset();
    steps(100);
    chk("to_pre_state", a_state, 0);
    chk("to_pre_cc", a_cc, 100);
    step();
    chk("to_state_a", a_state, 3);
    chk("to_flag_a", a_to, 1);
    chk("to_done_a", a_done, 1);
    chk("to_cc_a", a_cc, 100);
    chk("to_state_b", b_state, 3);
    evt = 3'b001;
    steps(5);
    chk("to_cc_hold", a_cc, 100);
    chk("to_evt_frozen", a_evt, 0);
    evt = '0; restart = 1'b1;
    step();
    restart = 1'b0;
    chk("to_restart_state", a_state, 0);
    chk("to_restart_cc", a_cc, 0);

    // Halt on the same cycle the limit is reached: halt wins.
    do_reset();
    steps(100);
    halt = 1'b1; ret_in = 16'd5;
    step();
    halt = 1'b0;
    chk("sim_state_a", a_state, 2);
    chk("sim_timeout_a", a_to, 0);
    chk("sim_ret_a", a_ret, 5);
    chk("sim_cc_a", a_cc, 101);
    chk("sim_state_b", b_state, 1);

    // Drain window on u_b with evt[1] held high throughout.
    do_reset();
    evt = 3'b010; sel = 2'd1;
    steps(10);
    chk("dr_pre_evt", b_evt, 10);
    halt = 1'b1; ret_in = 16'h002A;
    step();
    chk("dr0_state", b_state, 1);
    chk("dr0_done", b_done, 0);
    chk("dr0_evt", b_evt, 11);
    chk("halt_a_state", a_state, 2);
    chk("halt_a_evt", a_evt, 11);
    ret_in = 16'd7;
    step();
    halt = 1'b0;
    chk("dr1_state", b_state, 1);
    chk("dr1_cc", b_cc, 12);
    step();
    chk("dr2_state", b_state, 1);
    step();
    chk("dr_end_state", b_state, 2);
    chk("dr_end_done", b_done, 1);
    chk("dr_end_cc", b_cc, 14);
    chk("dr_end_evt", b_evt, 14);
    chk("dr_end_ret", b_ret, 42);
    steps(20);
    chk("dr_frozen_cc", b_cc, 14);
    chk("dr_frozen_evt", b_evt, 14);
    chk("dr_frozen_state", b_state, 2);
    chk("a_frozen_cc", a_cc, 11);

    // Saturation on channel 2; restart ignored while running.
    do_reset();
    evt = 3'b100; sel = 2'd2;
    steps(14);
    chk("sat14", a_evt, 14);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("sat15", a_evt, 15);
    chk("restart_ignored_cc", a_cc, 15);
    steps(5);
    chk("sat20", a_evt, 15);
    evt = '0;

    // Async reset mid-drain, between clock edges.
    do_reset();
    evt = 3'b001;
    steps(3);
    halt = 1'b1; ret_in = 16'd9;
    step();
    halt = 1'b0;
    chk("ar_pre_state", b_state, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_state", b_state, 0);
    chk("ar_cc", b_cc, 0);
    chk("ar_ret", b_ret, 0);
    chk("ar_evt", b_evt, 0);
    chk("ar_done_a", a_done, 0);
    step();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
